reg_file: RTL
=============

# reg_file

Parametrised multi-entry register file that succeeds the single 32-bit register. It stores DEPTH words of N bits, has one byte-enabled write port and two synchronous read ports, and provides a multi-cycle hardware clear sequence. It sits between the decode stage and the ALU and supplies both source operands per cycle.

## Interface
- N, 32, data width in bits; multiple of 8
- A, 5, address width; DEPTH = 2**A entries
- ZERO_REG, 1, when 1 entry 0 reads as zero and ignores writes
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- we  input  1  write enable
- waddr  input  A  write address
- wdata  input  N  write data
- wbe  input  N/8  byte enables; bit i gates wdata[8i+7:8i]
- raddr1  input  A  read address, port 1
- raddr2  input  A  read address, port 2
- rdata1  output  N  registered read data, port 1
- rdata2  output  N  registered read data, port 2
- clr  input  1  start clear sequence (sampled when idle)
- busy  output  1  clear sequence in progress

## Operation
- Reset (async, any time, including mid-clear): every entry = 0, rdata1 = rdata2 = 0, busy = 0, FSM = IDLE, clear pointer = 0.
- Write: at a rising edge with we = 1, FSM = IDLE, and not (ZERO_REG = 1 and waddr = 0), each byte i with wbe[i] = 1 takes wdata byte i; other bytes keep their value. wbe = 0 leaves the entry unchanged.
- Read: at every rising edge, rdataX <= entry[raddrX]. If ZERO_REG = 1 and raddrX = 0, rdataX <= 0. Reads are also serviced while busy and return current contents.
- Same-cycle write and read of one address: the behaviour is set by the macro in Configuration.
- FSM states:
  - IDLE: clr = 1 moves to CLEAR with pointer = 0, and busy = 1 from the next cycle. A write in the same cycle as clr is still performed.
  - CLEAR: each cycle writes 0 to entry[pointer] and increments the pointer. When pointer = DEPTH-1, it clears that entry and returns to IDLE, with busy = 0 on the following cycle. While in CLEAR, we and clr are ignored.
- Clear duration: exactly DEPTH cycles with busy = 1. The pointer wraps from DEPTH-1 to 0 on exit.
- A read of the entry being cleared in the same cycle returns its pre-clear value.

## Timing
- Read latency: 1 cycle. An address presented before edge k gives data valid after edge k.
- Write visible to reads sampled at edge k+1 or later (edge k itself only with bypass).
- busy rises 1 cycle after clr is accepted. It falls DEPTH cycles later.
- No combinational path from inputs to outputs.

## Configuration
- REG_FILE_BYPASS_EN defined: write-first behaviour. If we is accepted and waddr = raddrX (not the zero register), rdataX gets the byte-merged result: new bytes where wbe = 1, old bytes elsewhere.
- REG_FILE_BYPASS_EN undefined: read-first behaviour. rdataX gets the pre-write value in that case.

## Structure
- Shared package reg_file_pkg holds:
  - FSM state enum (IDLE, CLEAR)
  - byte-merge function merge_bytes(old, new, be)
  - default width/depth constants
- One sub-module, reg_file_clr_fsm, holds the state, pointer and busy logic, and outputs clear_en and clear_addr. The storage and read ports stay in reg_file.

## Test plan
- Reset then read addresses 3 and 7 -> rdata1 = rdata2 = 0, busy = 0.
- Write entry 5 = 32'hDEADBEEF with wbe = 4'hF, then write 32'h00000011 with wbe = 4'h1, then read 5 -> 32'hDEADBE11.
- ZERO_REG = 1: write 0 = 32'hFFFFFFFF, then read 0 -> 0. Write 31 = 21512, then read 31 -> 21512.
- Same-cycle write 9 = 2352521 with read 9, old value 0 -> rdata = 2352521 with the macro defined, 0 without it. The next read returns 2352521 either way.
- Fill all 32 entries, pulse clr -> busy high for exactly 32 cycles. A write of 13964 during busy is dropped, and all entries read 0 afterwards.
- Assert reset while the clear pointer = 10 -> busy = 0 immediately and all entries are 0. A new clr restarts from pointer 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: FSM state, default sizes and the byte-merge helper shared by reg_file.
// merge_bytes works at N_MAX width; callers extend and truncate around it.
package reg_file_pkg;
    localparam int N_DEF = 32;
    localparam int A_DEF = 5;
    localparam int N_MAX = 256;
    typedef enum logic {IDLE, CLEAR} state_t;
    function automatic logic [N_MAX-1:0] merge_bytes(input logic [N_MAX-1:0] old_w,
                                                     input logic [N_MAX-1:0] new_w,
                                                     input logic [N_MAX/8-1:0] be);
        logic [N_MAX-1:0] m;
        m = old_w;
        for (int i = 0; i < N_MAX/8; i++) if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/reg_file_clr_fsm.sv
// reg_file_clr_fsm: walks a pointer over every entry after clr, one entry per cycle.
module reg_file_clr_fsm import reg_file_pkg::*; #(
    parameter int A = A_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    output logic         busy,
    output logic         clear_en,
    output logic [A-1:0] clear_addr
);
    state_t         r_state;
    state_t         w_state_nxt;
    logic   [A-1:0] r_ptr;
    logic   [A-1:0] w_ptr_nxt;
    // The last entry is the all-ones address, so the pointer wraps to 0 on exit.
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (clr ? CLEAR : IDLE) : (&r_ptr ? IDLE : CLEAR);
        w_ptr_nxt   = (r_state == CLEAR) ? r_ptr + 1'b1 : r_ptr;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end
    assign busy       = (r_state == CLEAR);
    assign clear_en   = (r_state == CLEAR);
    assign clear_addr = r_ptr;
endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x N register file, one byte-enabled write port, two registered read ports.
// Define REG_FILE_BYPASS_EN for write-first reads of the address being written.
module reg_file import reg_file_pkg::*; #(
    parameter int N        = N_DEF,
    parameter int A        = A_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [A-1:0]   waddr,
    input  logic [N-1:0]   wdata,
    input  logic [N/8-1:0] wbe,
    input  logic [A-1:0]   raddr1,
    input  logic [A-1:0]   raddr2,
    output logic [N-1:0]   rdata1,
    output logic [N-1:0]   rdata2,
    input  logic           clr,
    output logic           busy
);
    localparam int DEPTH = 2**A;
    logic [N-1:0] r_mem [DEPTH];
    logic         w_clear_en;
    logic [A-1:0] w_clear_addr;
    logic         w_wr_ok;
    logic [N-1:0] w_merged;
    logic [N-1:0] w_rd1;
    logic [N-1:0] w_rd2;
    reg_file_clr_fsm #(.A(A)) u_clr_fsm (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .busy       (busy),
        .clear_en   (w_clear_en),
        .clear_addr (w_clear_addr)
    );
    assign w_wr_ok  = we && !w_clear_en && !(ZERO_REG != 0 && waddr == '0);
    assign w_merged = N'(merge_bytes(N_MAX'(r_mem[waddr]), N_MAX'(wdata), (N_MAX/8)'(wbe)));
`ifdef REG_FILE_BYPASS_EN
    assign w_rd1 = (w_wr_ok && waddr == raddr1) ? w_merged : r_mem[raddr1];
    assign w_rd2 = (w_wr_ok && waddr == raddr2) ? w_merged : r_mem[raddr2];
`else
    assign w_rd1 = r_mem[raddr1];
    assign w_rd2 = r_mem[raddr2];
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (w_clear_en) r_mem[w_clear_addr] <= '0;
            else if (w_wr_ok) r_mem[waddr] <= w_merged;
            rdata1 <= (ZERO_REG != 0 && raddr1 == '0) ? '0 : w_rd1;
            rdata2 <= (ZERO_REG != 0 && raddr2 == '0) ? '0 : w_rd2;
        end
    end
endmodule
